// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory master and its memory model
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    // Access width as carried on op_width / mem_width; 2'b11 is an alias for word.
    typedef enum logic [1:0] {
        WIDTH_BYTE     = 2'b00,
        WIDTH_HALF     = 2'b01,
        WIDTH_WORD     = 2'b10,
        WIDTH_WORD_ALT = 2'b11
    } width_e;

    // Completion status reported on resp_fault.
    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10
    } fault_e;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of bytes touched by an access of the given width encoding.
    function automatic int unsigned width_bytes(input logic [1:0] w);
        case (w)
            WIDTH_BYTE: return 1;
            WIDTH_HALF: return 2;
            default:    return 4;
        endcase
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// rtl/mem_master_if.sv - pipeline, response and memory-side signal bundle
interface mem_master_if;

    // pipeline access request
    logic        op_valid;
    logic        op_ready;
    logic        op_write;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [1:0]  op_width;
    logic        op_extend;

    // completion back to the pipeline
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;

    // memory request / completion
    logic        mem_req;
    logic        mem_write;
    logic        mem_extend;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // the memory master itself
    modport master (
        input  op_valid, op_write, op_addr, op_wdata, op_width, op_extend,
        input  resp_ready,
        input  mem_ack, mem_rdata,
        output op_ready,
        output resp_valid, resp_rdata, resp_fault,
        output mem_req, mem_write, mem_extend, mem_addr, mem_wdata, mem_width
    );

    // pipeline plus memory environment facing the master
    modport slave (
        output op_valid, op_write, op_addr, op_wdata, op_width, op_extend,
        output resp_ready,
        output mem_ack, mem_rdata,
        input  op_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  mem_req, mem_write, mem_extend, mem_addr, mem_wdata, mem_width
    );

endinterface

// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-outstanding load/store master with alignment and timeout faults
module mem_master
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_master_if.master bus
);

    // Last counter value before a request is abandoned.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_op_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic [1:0]        r_resp_fault;
    logic              r_mem_req;
    logic              r_mem_write;
    logic              r_mem_extend;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [1:0]        r_mem_width;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_timeout_hit;

    // Halfword must be 2-byte aligned, word (either encoding) 4-byte aligned.
    assign w_misaligned  = ((bus.op_width == WIDTH_HALF) && bus.op_addr[0])
                         || (bus.op_width[1] && (bus.op_addr[1:0] != 2'b00));
    assign w_accept      = bus.op_valid && r_op_ready;
    assign w_timeout_hit = (r_cnt == LP_CNT_LAST);

    // Sequencer: accept in IDLE, hold mem_* stable in REQ, present result in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_op_ready   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_fault <= FAULT_OK;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_extend <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_width  <= WIDTH_BYTE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // op_ready comes up on the first edge after reset release
                    r_op_ready <= 1'b1;
                    if (w_accept) begin
                        r_op_ready <= 1'b0;
                        if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_fault <= FAULT_MISALIGN;
                            r_state      <= ST_RESP;
                        end else begin
                            r_mem_req    <= 1'b1;
                            r_mem_write  <= bus.op_write;
                            r_mem_extend <= bus.op_extend;
                            r_mem_addr   <= bus.op_addr;
                            r_mem_wdata  <= bus.op_wdata;
                            r_mem_width  <= bus.op_width;
                            r_cnt        <= '0;
                            r_state      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (bus.mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_mem_write ? 32'h0 : bus.mem_rdata;
                        r_resp_fault <= FAULT_OK;
                        r_state      <= ST_RESP;
                    end else if (w_timeout_hit) begin
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_fault <= FAULT_TIMEOUT;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // op_ready stays low here, so no new op can slip in on the handoff edge
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= '0;
                        r_resp_fault <= FAULT_OK;
                        r_op_ready   <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_op_ready <= 1'b0;
                    r_mem_req  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_ready   = r_op_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_fault = r_resp_fault;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_extend = r_mem_extend;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_width  = r_mem_width;

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - randomized self-checking bench for mem_master
module tb_mem_master;
    import mem_pkg::*;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_master_if bus();

    mem_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // ---------------- memory model (byte array, configurable ack delay) ----------------
    logic [7:0] mem_bytes [0:255];
    int         ack_delay = 0;
    int         req_age   = 0;
    logic       ack_force = 1'b0;

    assign bus.mem_ack = ack_force | (bus.mem_req & (req_age >= ack_delay));

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) req_age <= req_age + 1;
        else                             req_age <= 0;
        if (bus.mem_req && bus.mem_ack && bus.mem_write)
            for (int i = 0; i < int'(width_bytes(bus.mem_width)); i++)
                mem_bytes[8'(int'(bus.mem_addr[7:0]) + i)] <= bus.mem_wdata[8*i +: 8];
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] w, input logic ext);
        int nb = int'(width_bytes(w));
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_bytes[8'(int'(a[7:0]) + i)];
        if (ext && nb < 4 && v[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    always @(negedge clk) bus.mem_rdata = mem_read(bus.mem_addr, bus.mem_width, bus.mem_extend);

    // ---------------- reference model (word array, shift/mask arithmetic) ----------------
    logic [31:0] ref_words [0:63];

    function automatic int ref_nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_mask(input int nb);
        return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 32'h1);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input logic ext);
        int nb = ref_nbytes(w);
        logic [31:0] m = ref_mask(nb);
        logic [31:0] v = (ref_words[a[7:2]] >> (8 * int'(a[1:0]))) & m;
        if (ext && nb < 4 && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        int sh = 8 * int'(a[1:0]);
        logic [31:0] m = ref_mask(ref_nbytes(w)) << sh;
        ref_words[a[7:2]] = (ref_words[a[7:2]] & ~m) | ((d << sh) & m);
    endtask

    function automatic logic any_output_set();
        return |{bus.op_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault, bus.mem_req,
                 bus.mem_write, bus.mem_extend, bus.mem_addr, bus.mem_wdata, bus.mem_width};
    endfunction

    // One complete access; called and returning on a falling edge.
    task automatic run_op(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] wid, input logic ext, input int d, input int hold,
                          output logic [31:0] got_rdata);
        int          nb      = ref_nbytes(wid);
        bit          mis     = (int'(a[7:0]) % nb) != 0;
        bit          tmo     = !mis && (d + 1 > TIMEOUT);
        logic [1:0]  e_fault = mis ? 2'b01 : (tmo ? 2'b10 : 2'b00);
        logic [31:0] e_rdata = (mis || tmo || w) ? 32'h0 : ref_load(a, wid, ext);
        int          e_req   = mis ? 0 : (tmo ? TIMEOUT : d + 1);
        int          guard   = 0;
        int          lat     = 1;
        int          reqc    = 0;
        int          bad     = 0;
        logic [31:0] h_rdata;
        logic [1:0]  h_fault;

        while (!bus.op_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ":op_ready"}, 64'(bus.op_ready), 64'd1);
        ack_delay     = d;
        bus.op_valid  = 1'b1;
        bus.op_write  = w;
        bus.op_addr   = a;
        bus.op_wdata  = wd;
        bus.op_width  = wid;
        bus.op_extend = ext;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        while (!bus.resp_valid && lat < 40) begin
            if (bus.mem_req) begin
                reqc++;
                if ({bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_width, bus.mem_extend}
                    !== {w, a, wd, wid, ext}) bad++;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"},    64'(lat),  64'(e_req + 1));
        check({tag, ":req_cycles"}, 64'(reqc), 64'(e_req));
        check({tag, ":mem_fields"}, 64'(bad),  64'd0);
        check({tag, ":fault"},      64'(bus.resp_fault), 64'(e_fault));
        check({tag, ":rdata"},      64'(bus.resp_rdata), 64'(e_rdata));
        check({tag, ":req_low"},    64'({bus.mem_req, bus.op_ready}), 64'd0);

        h_rdata = bus.resp_rdata;
        h_fault = bus.resp_fault;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_rdata !== h_rdata || bus.resp_fault !== h_fault
                || bus.op_ready || bus.mem_req) bad++;
        end
        if (hold > 0) check({tag, ":hold_stable"}, 64'(bad), 64'd0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, ":done"}, 64'({bus.resp_valid, bus.op_ready}), 64'b01);
        if (!mis && !tmo && w) ref_store(a, wid, wd);
        got_rdata = h_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          d;
        int          hold;
        int          bad;
        int          guard;

        bus.op_valid   = 1'b0;
        bus.op_write   = 1'b0;
        bus.op_addr    = '0;
        bus.op_wdata   = '0;
        bus.op_width   = 2'b00;
        bus.op_extend  = 1'b0;
        bus.resp_ready = 1'b0;
        reset_n        = 1'b0;
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'h00;
        for (int i = 0; i < 64; i++)  ref_words[i] = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst:outputs_zero", 64'(any_output_set()), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst:op_ready_after", 64'(bus.op_ready), 64'd1);

        // directed scenarios
        run_op("st_w4", 1'b1, 32'h4, 32'h8000_00F0, 2'b10, 1'b0, 0, 0, r);
        run_op("ld_b4", 1'b0, 32'h4, 32'h0, 2'b00, 1'b1, 0, 0, r);
        check("ld_b4:const", 64'(r), 64'hFFFF_FFF0);
        run_op("st_h6", 1'b1, 32'h6, 32'h0000_BEEF, 2'b01, 1'b0, 0, 0, r);
        run_op("ld_w4", 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 0, 0, r);
        check("ld_w4:const", 64'(r), 64'hBEEF_00F0);
        run_op("ld_w2_mis", 1'b0, 32'h2, 32'h0, 2'b10, 1'b0, 0, 0, r);
        run_op("ld_h5_mis", 1'b0, 32'h5, 32'h0, 2'b01, 1'b0, 0, 0, r);
        run_op("tmo_never", 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 1000, 0, r);
        run_op("ack_at_last", 1'b0, 32'h4, 32'h0, 2'b11, 1'b0, TIMEOUT - 1, 0, r);
        check("ack_at_last:const", 64'(r), 64'hBEEF_00F0);
        run_op("st_tmo", 1'b1, 32'h4, 32'h1234_5678, 2'b10, 1'b0, TIMEOUT, 0, r);
        run_op("ld_after_tmo", 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 1, 0, r);
        check("ld_after_tmo:const", 64'(r), 64'hBEEF_00F0);
        run_op("hold5", 1'b0, 32'h4, 32'h0, 2'b01, 1'b1, 2, 5, r);

        // memory ack outside a request must be ignored
        ack_force = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_req || bus.resp_valid || !bus.op_ready) bad++;
        end
        ack_force = 1'b0;
        check("stray_ack_idle", 64'(bad), 64'd0);

        // randomized accesses
        for (int k = 0; k < 60; k++) begin
            d = $urandom_range(0, 9);
            if (d == 8) d = TIMEOUT - 1;
            if (d == 9) d = 1000;
            hold = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                   $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d, hold, r);
        end

        // reset in the middle of a request
        ack_delay     = 1000;
        bus.op_valid  = 1'b1;
        bus.op_write  = 1'b1;
        bus.op_addr   = 32'h10;
        bus.op_wdata  = 32'hDEAD_BEEF;
        bus.op_width  = 2'b10;
        bus.op_extend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req:in_req", 64'(bus.mem_req), 64'd1);
        #2 reset_n = 1'b0;
        #1 check("rst_req:outputs_zero", 64'(any_output_set()), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ack_delay = 0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_req) bad++;
        end
        check("rst_req:no_resp", 64'(bad), 64'd0);
        check("rst_req:op_ready", 64'(bus.op_ready), 64'd1);

        // reset while a response is waiting
        bus.op_valid  = 1'b1;
        bus.op_write  = 1'b0;
        bus.op_addr   = 32'h4;
        bus.op_width  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        guard = 0;
        while (!bus.resp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("rst_resp:in_resp", 64'(bus.resp_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1 check("rst_resp:outputs_zero", 64'(any_output_set()), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_req) bad++;
        end
        check("rst_resp:no_resp", 64'(bad), 64'd0);
        run_op("post_rst_ld", 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 0, 0, r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the max cycles mem_req stays high awaiting mem_ack (legal 2..255).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 op_valid  input  1  pipeline presents an access.
REQ-005 op_ready  output  1  block accepts access this cycle.
REQ-006 op_write  input  1  1=store, 0=load.
REQ-007 op_addr  input  32  byte address.
REQ-008 op_wdata  input  32  store data, right-aligned.
REQ-009 op_width  input  2  00 byte, 01 half, 10/11 word.
REQ-010 op_extend  input  1  sign-extend load result.
REQ-011 resp_valid / resp_ready  output / input  1 / 1  completion handshake.
REQ-012 resp_rdata  output  32  load data; 0 for stores and faults.
REQ-013 resp_fault  output  2  00 ok, 01 misaligned, 10 timeout.
REQ-014 mem_req, mem_write, mem_extend  output  1 each  memory request controls.
REQ-015 mem_addr, mem_wdata  output  32 each; mem_width  output  2.
REQ-016 mem_ack  input  1; mem_rdata  input  32  memory completion and load data.

Function
REQ-017 FSM states IDLE, REQ, RESP SHALL be the only states; op_ready=1 only in IDLE.
REQ-018 IDLE, op_valid=1: misaligned (half with addr[0]=1, word with addr[1:0]!=0) SHALL go RESP, fault=01, no mem_req.
REQ-019 IDLE, op_valid=1, aligned: all op_* fields latched onto mem_* registers, mem_req<=1, timeout counter<=0, go REQ.
REQ-020 mem_* outputs SHALL be registered and stable throughout REQ.
REQ-021 REQ, mem_ack=1: mem_req<=0 on that edge, resp_rdata<=mem_rdata (load) or 0 (store), fault=00, go RESP.
REQ-022 mem_req SHALL never be high in the cycle after mem_ack sampled high (prevents re-trigger of memory).
REQ-023 REQ, no ack, counter=TIMEOUT-1: mem_req<=0, fault=10, resp_rdata=0, go RESP; else counter+1.
REQ-024 Ack and timeout on same cycle: ack SHALL win (fault=00).
REQ-025 Against a one-cycle-ack memory, resp_valid SHALL rise 2 cycles after acceptance edge.
REQ-026 RESP: resp_valid=1, resp_* held stable until resp_ready=1; then go IDLE (no op accepted that same cycle).
REQ-027 mem_ack outside REQ SHALL be ignored.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, counter 0, and all outputs 0 except op_ready=0 during reset, 1 after release.
REQ-029 Reset mid-REQ or mid-RESP SHALL drop the transaction with no response.

Structure
REQ-030 Width encodings, fault codes and FSM state enum SHALL live in shared package mem_pkg, reused by memory model.
REQ-031 No sub-module; single module, alignment check inline.

Verification
REQ-032 Word 0x8000_00F0 at addr 0x4; load byte addr 0x4 extend=1 -> resp_rdata 0xFFFF_FFF0, fault 00, resp_valid 2 cycles after accept.
REQ-033 Store half 0xBEEF addr 0x6, then load word addr 0x4 -> 0xBEEF_00F0; mem_req high exactly one cycle per access.
REQ-034 Load word addr 0x2 -> fault 01, rdata 0, mem_req never asserted.
REQ-035 mem_ack tied 0, TIMEOUT=16 -> mem_req high 16 cycles, then fault 10.
REQ-036 resp_ready held 0 for 5 cycles -> resp_* stable, op_ready 0; reset_n pulsed mid-REQ -> all outputs 0, no response.
